spi_peripheral: RTL and testbench
=================================

// Module: spi_peripheral
// PURPOSE
//   SPI responder (target) that faces an external SPI controller, such as our clock_divider-driven master.
//   Oversamples SCLK/CS_n/MOSI on the system clock, shifts WIDTH-bit words full-duplex.
//   Presents a one-entry TX buffer (valid/ready) and an RX word strobe to local logic.
//   All four SPI modes; mode latched while CS_n is high.
// PARAMETERS
//   WIDTH        8  bits per word
//   SYNC_STAGES  2  flip-flops per input synchronizer (>=2)
// PORTS
//   i_clk       in   1      system clock; must be >= 8x SCLK frequency
//   i_rst       in   1      asynchronous, active-high reset
//   i_config    in   2      {CPOL,CPHA}; sampled only while synced CS_n is high
//   i_sclk      in   1      SPI clock from controller (async)
//   i_cs_n      in   1      chip select, active-low (async)
//   i_mosi      in   1      controller-out data (async)
//   o_miso      out  1      peripheral-out data
//   o_miso_oe   out  1      MISO drive enable (=~synced CS_n)
//   i_tx_data   in   WIDTH  next word to transmit
//   i_tx_valid  in   1      TX word offered
//   o_tx_ready  out  1      TX buffer empty; load on i_tx_valid&&o_tx_ready
//   o_rx_data   out  WIDTH  last complete received word; held until next
//   o_rx_valid  out  1      1-cycle pulse per complete word
// BEHAVIOUR
//   Reset: o_miso=1, o_miso_oe=0, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, state IDLE, mode=0.
//   Inputs pass SYNC_STAGES FFs; SCLK rise/fall and CS_n fall/rise detected on synced values.
//   Leading edge = rise if CPOL=0 else fall; trailing = opposite.
//   FSM IDLE->ACTIVE on CS_n fall; ACTIVE->IDLE on CS_n rise. No other states.
//   Word load (CS_n fall, or word boundary while ACTIVE): shift_reg<=TX buffer, buffer emptied,
//     o_tx_ready=1 next cycle. Empty buffer: load all-ones (underrun). MSB first.
//   CPHA=0: MSB on o_miso from load; sample MOSI on leading, shift MISO on trailing edge.
//   CPHA=1: shift MISO on leading (first leading edge presents MSB), sample on trailing edge.
//   Bit counter 0..WIDTH-1. On WIDTH-th sample: o_rx_data<=word, o_rx_valid=1 on the next
//     cycle, counter wraps to 0; next word is loaded at the following shift edge (CPHA=1) or
//     immediately (CPHA=0).
//   Buffer load and word load in the same cycle: the loaded word goes out, the new word is
//     buffered, and o_tx_ready stays 0.
//   CS_n rise mid-word: partial word discarded, no o_rx_valid, counter cleared, and the
//     shift-register word is lost (the buffer is kept).
//   SCLK edges while CS_n high are ignored. i_config changes while ACTIVE are ignored.
//   o_rx_valid has no backpressure: an unread word is overwritten.
//   Async reset mid-transfer returns to IDLE immediately; the next CS_n fall starts clean.
// CONFIGURATION
//   SPI_PERIPH_STATUS_EN defined: adds o_status[1:0] = {rx_overrun, tx_underrun} and i_status_clr.
//     Bits are sticky and cleared by i_status_clr. Clear and set in the same cycle: set wins.
//     rx_overrun means a new word completed while the previous o_rx_valid word was unacknowledged
//     (i_status_clr counts as acknowledge).
//   SPI_PERIPH_STATUS_EN undefined: ports absent; underrun still sends all-ones silently.
// STRUCTURE
//   spi_pkg: typedef spi_mode_t {CPOL,CPHA}; typedef enum spi_periph_state_t {IDLE,ACTIVE};
//     localparam SPI_MIN_OVERSAMPLE=8.
//   Sub-module spi_sync: SYNC_STAGES synchronizer plus rise/fall detect, one instance each
//     for SCLK, CS_n and MOSI.
// TESTING (bench model controller with SCLK = i_clk/8)
//   mode0: tx 0xA5 preloaded, controller sends 0x3C -> MISO sees 0xA5, o_rx_data=0x3C, one rx pulse
//   mode3 ({1,1}): tx 0x81, MOSI 0x7E -> MISO 0x81, o_rx_data=0x7E; config change while ACTIVE ignored
//   back-to-back: load 0x11, then 0x22 after first o_tx_ready, 16 SCLKs one CS_n -> MISO 0x11,0x22; two rx pulses
//   underrun: no tx loaded, CS_n low 8 SCLKs -> MISO 0xFF; status[0]=1 if STATUS_EN
//   abort: CS_n rises after 3 bits -> no o_rx_valid, o_rx_data unchanged; next full word correct
//   reset: assert i_rst mid-word -> all outputs at reset values same cycle; fresh transfer correct

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared types and constants for the SPI peripheral.
//   - spi_mode_t          : {CPOL, CPHA} as driven on i_config
//   - spi_periph_state_t  : chip-select FSM states
//   - SPI_MIN_OVERSAMPLE  : minimum i_clk / SCLK ratio the edge detectors need
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_periph_state_t;

    localparam int SPI_MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
//   Multi-flop synchronizer for one asynchronous input, followed by rise/fall
//   detection on the synchronized value.
// Ports
//   i_clk, i_rst  system clock, asynchronous active-high reset
//   i_async       asynchronous input
//   o_sync        synchronized level
//   o_rise        one-cycle pulse on a 0->1 transition of o_sync
//   o_fall        one-cycle pulse on a 1->0 transition of o_sync
// Parameters
//   SYNC_STAGES   number of synchronizer flops (>= 2)
//   RST_VAL       level the chain resets to (idle level of the input)
// -----------------------------------------------------------------------------
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];
    assign o_rise = o_sync & ~prev_q;
    assign o_fall = ~o_sync & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// -----------------------------------------------------------------------------
// spi_peripheral
//   SPI target. SCLK, CS_n and MOSI are oversampled on i_clk (>= 8x SCLK),
//   words of WIDTH bits are shifted full-duplex, MSB first, in any SPI mode.
//   Local logic sees a one-entry TX buffer (valid/ready) and an RX strobe.
// Ports
//   i_clk, i_rst            system clock, asynchronous active-high reset
//   i_config[1:0]           {CPOL,CPHA}, taken only while CS_n is high
//   i_sclk, i_cs_n, i_mosi  SPI bus inputs (asynchronous)
//   o_miso, o_miso_oe       SPI data out and its drive enable
//   i_tx_data, i_tx_valid   next word to send, offered to the buffer
//   o_tx_ready              buffer empty
//   o_rx_data, o_rx_valid   last received word, one-cycle strobe per word
// Optional feature (macro SPI_PERIPH_STATUS_EN)
//   o_status[1:0]           sticky {rx_overrun, tx_underrun}
//   i_status_clr            clears status; also acknowledges the RX word
// -----------------------------------------------------------------------------
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_config,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
`ifdef SPI_PERIPH_STATUS_EN
    output logic [1:0]       o_status,
    input  logic             i_status_clr,
`endif
    output logic             o_rx_valid
);

    localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    // Synchronized bus inputs
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_sclk),
        .o_sync(sclk_lvl_unused), .o_rise(sclk_rise), .o_fall(sclk_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_cs_n),
        .o_sync(cs_s), .o_rise(cs_rise), .o_fall(cs_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_async(i_mosi),
        .o_sync(mosi_s), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
    );

    // State
    spi_periph_state_t state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              miso_q, miso_d;
    logic              reload_q, reload_d;     // CPHA=1: next word due at next shift edge
    logic              buf_full_q, buf_full_d;
    logic [WIDTH-1:0]  rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    // Data-only registers (no reset needed)
    logic [WIDTH-1:0]  buf_q, buf_d;
    logic [WIDTH-1:0]  tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0]  rx_sh_q, rx_sh_d;

    logic              lead, trail, sample_edge, shift_edge;
    logic [WIDTH-1:0]  next_word, rx_word;
    logic              load_word, word_done, accept;

    assign lead        = mode_q.cpol ? sclk_fall : sclk_rise;
    assign trail       = mode_q.cpol ? sclk_rise : sclk_fall;
    assign sample_edge = mode_q.cpha ? trail : lead;
    assign shift_edge  = mode_q.cpha ? lead  : trail;
    // Empty buffer at a word boundary sends all-ones.
    assign next_word   = buf_full_q ? buf_q : {WIDTH{1'b1}};
    assign rx_word     = {rx_sh_q[WIDTH-2:0], mosi_s};
    assign accept      = i_tx_valid && !buf_full_q;

    // Next-state state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            cnt_q      <= '0;
            miso_q     <= 1'b1;
            reload_q   <= 1'b0;
            buf_full_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            reload_q   <= reload_d;
            buf_full_q <= buf_full_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        buf_q   <= buf_d;
        tx_sh_q <= tx_sh_d;
        rx_sh_q <= rx_sh_d;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        reload_d   = reload_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        rx_data_d  = rx_data_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        load_word  = 1'b0;
        word_done  = 1'b0;

        // Mode only follows i_config while deselected, so a change mid-frame is ignored.
        if (cs_s) begin
            mode_d = i_config;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    load_word = 1'b1;
                    cnt_d     = '0;
                    reload_d  = 1'b0;
                    rx_sh_d   = '0;
                    if (mode_q.cpha) begin
                        // MSB appears on the first leading edge.
                        tx_sh_d = next_word;
                    end else begin
                        miso_d  = next_word[WIDTH-1];
                        tx_sh_d = next_word << 1;
                    end
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    // Abort: partial word and shift-register contents are dropped.
                    state_d  = IDLE;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_sh_d = rx_word;
                        if (cnt_q == LAST) begin
                            cnt_d     = '0;
                            word_done = 1'b1;
                            rx_data_d = rx_word;
                            if (mode_q.cpha) begin
                                reload_d = 1'b1;
                            end else begin
                                load_word = 1'b1;
                                miso_d    = next_word[WIDTH-1];
                                tx_sh_d   = next_word << 1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (mode_q.cpha && reload_q) begin
                            load_word = 1'b1;
                            reload_d  = 1'b0;
                            miso_d    = next_word[WIDTH-1];
                            tx_sh_d   = next_word << 1;
                        end else if (mode_q.cpha || (cnt_q != '0)) begin
                            // CPHA=0: the trailing edge right after a word boundary
                            // must keep the freshly loaded MSB on the line.
                            miso_d  = tx_sh_q[WIDTH-1];
                            tx_sh_d = tx_sh_q << 1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A word load empties the buffer; a same-cycle offer refills it.
        if (load_word) begin
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_d      = i_tx_data;
            buf_full_d = 1'b1;
        end
    end

    assign rx_valid_d = word_done;

`ifdef SPI_PERIPH_STATUS_EN
    logic [1:0] status_q, status_d;
    logic       pending_q, pending_d;
    logic       underrun_set, overrun_set;

    assign underrun_set = load_word && !buf_full_q;
    assign overrun_set  = word_done && pending_q && !i_status_clr;

    always_comb begin
        pending_d = pending_q;
        if (i_status_clr) begin
            pending_d = 1'b0;
        end
        if (word_done) begin
            pending_d = 1'b1;
        end
        status_d = i_status_clr ? 2'b00 : status_q;
        status_d = status_d | {overrun_set, underrun_set};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            status_q  <= 2'b00;
            pending_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            pending_q <= pending_d;
        end
    end

    assign o_status = status_q;
`endif

    assign o_miso     = miso_q;
    assign o_miso_oe  = ~cs_s;
    assign o_tx_ready = ~buf_full_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_peripheral.sv
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cfg;
    logic       sclk, cs_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
`ifdef SPI_PERIPH_STATUS_EN
    logic [1:0] status;
    logic       status_clr;
`endif

    always #5 clk = ~clk;

    spi_peripheral #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_config(cfg),
        .i_sclk(sclk),
        .i_cs_n(cs_n),
        .i_mosi(mosi),
        .o_miso(miso),
        .o_miso_oe(miso_oe),
        .i_tx_data(tx_data),
        .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready),
        .o_rx_data(rx_data),
`ifdef SPI_PERIPH_STATUS_EN
        .o_status(status),
        .i_status_clr(status_clr),
`endif
        .o_rx_valid(rx_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // RX strobe monitor, sampled away from the active edge.
    int         rx_count = 0;
    logic [7:0] rx_hist[64];
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_hist[rx_count % 64] = rx_data;
            rx_count = rx_count + 1;
        end
    end

    typedef struct {
        logic [1:0] mode;
        logic [1:0] mid_cfg;
        logic       load;
        logic [7:0] tx;
        logic [7:0] mosi_w;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_tx(input logic [7:0] d);
        int t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_wait", {31'b0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        cfg  = m;
        sclk = m[1];
        repeat (8) @(negedge clk);
    endtask

    // Model controller: SCLK = clk/8, all changes on clk negedges.
    task automatic spi_xfer(input logic [1:0] mode, input logic [1:0] mid_cfg,
                            input logic [15:0] mosi_w, input int nbits,
                            output logic [15:0] miso_w);
        logic cpol, cpha;
        cpol   = mode[1];
        cpha   = mode[0];
        miso_w = '0;
        sclk   = cpol;
        cs_n   = 1'b0;
        if (!cpha) mosi = mosi_w[nbits-1];
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            if (b == 3) cfg = mid_cfg;
            sclk = ~cpol;
            if (cpha) mosi = mosi_w[nbits-1-b];
            else      miso_w = {miso_w[14:0], miso};
            repeat (4) @(negedge clk);
            sclk = cpol;
            if (cpha)            miso_w = {miso_w[14:0], miso};
            else if (b < nbits-1) mosi = mosi_w[nbits-2-b];
            repeat (4) @(negedge clk);
        end
        cfg = mode;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [15:0] got;
        int          c0;
        int          t;

        rst      = 1'b1;
        cfg      = 2'b00;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
`ifdef SPI_PERIPH_STATUS_EN
        status_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_miso",     {31'b0, miso},     32'd1);
        check("rst_miso_oe",  {31'b0, miso_oe},  32'd0);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_rx_data",  {24'b0, rx_data},  32'd0);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        vecs[0] = '{mode: 2'b00, mid_cfg: 2'b00, load: 1'b1, tx: 8'hA5, mosi_w: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
        vecs[1] = '{mode: 2'b11, mid_cfg: 2'b00, load: 1'b1, tx: 8'h81, mosi_w: 8'h7E, exp_miso: 8'h81, exp_rx: 8'h7E};
        vecs[2] = '{mode: 2'b01, mid_cfg: 2'b01, load: 1'b1, tx: 8'h5C, mosi_w: 8'hC5, exp_miso: 8'h5C, exp_rx: 8'hC5};
        vecs[3] = '{mode: 2'b10, mid_cfg: 2'b10, load: 1'b1, tx: 8'hE7, mosi_w: 8'h18, exp_miso: 8'hE7, exp_rx: 8'h18};
        vecs[4] = '{mode: 2'b00, mid_cfg: 2'b00, load: 1'b0, tx: 8'h00, mosi_w: 8'h96, exp_miso: 8'hFF, exp_rx: 8'h96};

        for (int i = 0; i < 5; i++) begin
            set_mode(vecs[i].mode);
            if (vecs[i].load) begin
                load_tx(vecs[i].tx);
                check($sformatf("v%0d_ready_low", i), {31'b0, tx_ready}, 32'd0);
            end
            c0 = rx_count;
            spi_xfer(vecs[i].mode, vecs[i].mid_cfg, {8'h00, vecs[i].mosi_w}, 8, got);
            check($sformatf("v%0d_oe_active", i), {31'b0, miso_oe}, 32'd1);
            cs_high();
            check($sformatf("v%0d_miso", i),     {24'b0, got[7:0]}, {24'b0, vecs[i].exp_miso});
            check($sformatf("v%0d_rx_data", i),  {24'b0, rx_data},  {24'b0, vecs[i].exp_rx});
            check($sformatf("v%0d_rx_pulses", i), rx_count - c0,    32'd1);
            check($sformatf("v%0d_ready_end", i), {31'b0, tx_ready}, 32'd1);
            check($sformatf("v%0d_oe_idle", i),  {31'b0, miso_oe},  32'd0);
`ifdef SPI_PERIPH_STATUS_EN
            check($sformatf("v%0d_underrun", i), {31'b0, status[0]}, {31'b0, ~vecs[i].load});
            status_clr = 1'b1;
            @(negedge clk);
            status_clr = 1'b0;
`endif
        end

        // Back-to-back: two words in one frame, second offered once the buffer frees.
        set_mode(2'b00);
        load_tx(8'h11);
        c0 = rx_count;
        fork
            spi_xfer(2'b00, 2'b00, 16'hC35A, 16, got);
            begin
                t = 0;
                while (tx_ready !== 1'b1 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                load_tx(8'h22);
            end
        join
        cs_high();
        check("b2b_miso",   {16'b0, got},     32'h1122);
        check("b2b_pulses", rx_count - c0,    32'd2);
        check("b2b_rx0",    {24'b0, rx_hist[c0 % 64]},       32'hC3);
        check("b2b_rx1",    {24'b0, rx_hist[(c0 + 1) % 64]}, 32'h5A);

        // Abort after 3 bits: nothing received, then a clean word.
        load_tx(8'h33);
        c0 = rx_count;
        spi_xfer(2'b00, 2'b00, 16'h0005, 3, got);
        cs_high();
        check("abort_pulses",  rx_count - c0,   32'd0);
        check("abort_rx_data", {24'b0, rx_data}, 32'h5A);
        load_tx(8'h96);
        spi_xfer(2'b00, 2'b00, 16'h0069, 8, got);
        cs_high();
        check("post_abort_miso", {24'b0, got[7:0]}, 32'h96);
        check("post_abort_rx",   {24'b0, rx_data},  32'h69);
        check("post_abort_pulses", rx_count - c0,   32'd1);

        // Asynchronous reset in the middle of a word.
        load_tx(8'h3C);
        cs_n = 1'b0;
        sclk = 1'b0;
        mosi = 1'b1;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("pre_rst_oe", {31'b0, miso_oe}, 32'd1);
        check("pre_rst_rx_data", {24'b0, rx_data}, 32'h69);
        rst = 1'b1;
        #1;
        check("mid_rst_miso",     {31'b0, miso},     32'd1);
        check("mid_rst_oe",       {31'b0, miso_oe},  32'd0);
        check("mid_rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("mid_rst_rx_data",  {24'b0, rx_data},  32'd0);
        check("mid_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        c0 = rx_count;
        load_tx(8'hC6);
        spi_xfer(2'b00, 2'b00, 16'h005B, 8, got);
        cs_high();
        check("post_rst_miso",   {24'b0, got[7:0]}, 32'hC6);
        check("post_rst_rx",     {24'b0, rx_data},  32'h5B);
        check("post_rst_pulses", rx_count - c0,     32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
